fetch_pc_gen: RTL and testbench



---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_block_decode.sv | 29 ++
 rtl/fetch_pc_gen.sv | 158 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch PC generator
package fetch_pkg;

  // Widest slot index and branch ID the S1 record can carry.
  localparam int SLOT_W_MAX = 8;
  localparam int BID_W_MAX  = 32;

  // Branch ID value meaning "no branch in this slot".
  localparam logic [BID_W_MAX-1:0] BID_NONE = '1;

  // Width of a slot index for a block of n slots (at least one bit).
  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Stage-1 record: the block that was fetched and how to format it.
  typedef struct packed {
    logic [30:0]           pc_last;
    logic [SLOT_W_MAX-1:0] start;
    logic [SLOT_W_MAX-1:0] end_slot;
    logic [SLOT_W_MAX-1:0] bslot;
    logic [BID_W_MAX-1:0]  bid;
    logic                  pred;
  } s1_t;

endpackage

// File: rtl/fetch_block_decode.sv
// rtl/fetch_block_decode.sv - expands the S1 record into per-slot valid, ID and pred vectors
module fetch_block_decode
  import fetch_pkg::*;
#(
  parameter int NUM_UOPS = 2,
  parameter int BID_W    = 6,
  parameter int SW       = slot_w(NUM_UOPS)
) (
  input  logic [SW-1:0]             start,
  input  logic [SW-1:0]             end_slot,
  input  logic [SW-1:0]             bslot,
  input  logic [BID_W-1:0]          bid,
  input  logic                      pred,
  output logic [NUM_UOPS-1:0]       valid,
  output logic [NUM_UOPS*BID_W-1:0] branch_id,
  output logic [NUM_UOPS-1:0]       branch_pred
);

  localparam logic [BID_W-1:0] NONE = BID_NONE[BID_W-1:0];

  // Each slot is live inside [start, end]; only the branch slot carries the ID and prediction.
  for (genvar i = 0; i < NUM_UOPS; i++) begin : g_slot
    localparam logic [SW-1:0] IDX = SW'(i);
    assign valid[i]                    = (IDX >= start) && (IDX <= end_slot);
    assign branch_id[i*BID_W +: BID_W] = (IDX == bslot) ? bid : NONE;
    assign branch_pred[i]              = pred && (IDX == bslot);
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch address generator and fetch-block formatter
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int          NUM_UOPS = 2,
  parameter int          BID_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      IN_write,
  input  logic [31:0]               IN_pc,
  input  logic                      IN_BP_branchFound,
  input  logic                      IN_BP_branchTaken,
  input  logic                      IN_BP_isJump,
  input  logic [31:0]               IN_BP_branchSrc,
  input  logic [31:0]               IN_BP_branchDst,
  input  logic [BID_W-1:0]          IN_BP_branchID,
  input  logic                      IN_BP_multipleBranches,
  input  logic [NUM_UOPS*32-1:0]    IN_instr,
  input  logic                      IN_ready,
  input  logic [31:0]               IN_instrMappingBase,
  input  logic [31:0]               IN_instrMappingMask,
  output logic [31:0]               OUT_pcRaw,
  output logic                      OUT_fetchEn,
  output logic                      OUT_valid,
  output logic [NUM_UOPS*32-1:0]    OUT_pc,
  output logic [NUM_UOPS*32-1:0]    OUT_instr,
  output logic [NUM_UOPS-1:0]       OUT_instrValid,
  output logic [NUM_UOPS*BID_W-1:0] OUT_branchID,
  output logic [NUM_UOPS-1:0]       OUT_branchPred,
  output logic                      OUT_instrMappingMiss
);

  localparam int          SW       = slot_w(NUM_UOPS);
  localparam int          B        = $clog2(NUM_UOPS * 4);
  // Halfword-unit block size and the mask that aligns a halfword pc to a block.
  localparam logic [30:0] BLK_HW   = 31'(NUM_UOPS * 2);
  localparam logic [30:0] ALIGN_HW = ~31'((1 << (B - 1)) - 1);

  logic [30:0] pc;
  logic [30:0] pc_nx;
  s1_t         s1;
  s1_t         s1_nx;
  logic        v1;
  logic        adv0;
  logic        adv2;

  logic [SW-1:0] start_slot;
  logic [SW-1:0] bp_slot;

  logic [NUM_UOPS-1:0]       dec_valid;
  logic [NUM_UOPS*BID_W-1:0] dec_bid;
  logic [NUM_UOPS-1:0]       dec_pred;
  logic [31:0]               blk_base;
  logic [NUM_UOPS*32-1:0]    blk_pc;

  // S2 drains when the decoder takes it or it is empty; S0/S1 move when S1 can hand off.
  assign adv2        = v1 && (!OUT_valid || IN_ready);
  assign adv0        = !v1 || adv2;
  assign OUT_fetchEn = adv0 && !IN_write;
  assign OUT_pcRaw   = {pc, 1'b0};

  assign OUT_instrMappingMiss = |((OUT_pcRaw ^ IN_instrMappingBase) & IN_instrMappingMask);

  assign start_slot = pc[B-2:1];
  assign bp_slot    = IN_BP_branchSrc[B-1:2];

  // Pick the next fetch address and describe the current block from the predictor result.
  always_comb begin
    pc_nx          = (pc & ALIGN_HW) + BLK_HW;
    s1_nx          = '0;
    s1_nx.pc_last  = pc;
    s1_nx.start    = SLOT_W_MAX'(start_slot);
    s1_nx.end_slot = SLOT_W_MAX'(NUM_UOPS - 1);
    s1_nx.bslot    = SLOT_W_MAX'(bp_slot);
    s1_nx.bid      = BID_NONE;
    s1_nx.pred     = 1'b0;
    if (IN_BP_branchFound) begin
      // A not-taken last branch still tags its slot but leaves the block running to the end.
      s1_nx.bid = BID_W_MAX'(IN_BP_branchID);
      if (IN_BP_branchTaken || IN_BP_isJump) begin
        pc_nx          = IN_BP_branchDst[31:1];
        s1_nx.end_slot = SLOT_W_MAX'(bp_slot);
        s1_nx.pred     = 1'b1;
      end else if (IN_BP_multipleBranches) begin
        pc_nx          = IN_BP_branchSrc[31:1] + 31'd2;
        s1_nx.end_slot = SLOT_W_MAX'(bp_slot);
      end
    end
  end

  // Fetch address and stage-1 record; a redirect wins over the predictor and empties S1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC[31:1];
      s1 <= '0;
      v1 <= 1'b0;
    end else if (IN_write) begin
      pc <= IN_pc[31:1];
      v1 <= 1'b0;
    end else if (adv0) begin
      pc <= pc_nx;
      s1 <= s1_nx;
      v1 <= 1'b1;
    end
  end

  fetch_block_decode #(
    .NUM_UOPS (NUM_UOPS),
    .BID_W    (BID_W),
    .SW       (SW)
  ) u_decode (
    .start       (s1.start[SW-1:0]),
    .end_slot    (s1.end_slot[SW-1:0]),
    .bslot       (s1.bslot[SW-1:0]),
    .bid         (s1.bid[BID_W-1:0]),
    .pred        (s1.pred),
    .valid       (dec_valid),
    .branch_id   (dec_bid),
    .branch_pred (dec_pred)
  );

  assign blk_base = {s1.pc_last & ALIGN_HW, 1'b0};

  for (genvar i = 0; i < NUM_UOPS; i++) begin : g_pc
    assign blk_pc[i*32 +: 32] = blk_base + 32'(4 * i);
  end

  // Output block registers: load on hand-off, hold under back-pressure, drop on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_valid      <= 1'b0;
      OUT_pc         <= '0;
      OUT_instr      <= '0;
      OUT_instrValid <= '0;
      OUT_branchID   <= {NUM_UOPS{BID_NONE[BID_W-1:0]}};
      OUT_branchPred <= '0;
    end else if (IN_write) begin
      OUT_valid <= 1'b0;
    end else if (adv2) begin
      OUT_valid      <= 1'b1;
      OUT_pc         <= blk_pc;
      OUT_instr      <= IN_instr;
      OUT_instrValid <= dec_valid;
      OUT_branchID   <= dec_bid;
      OUT_branchPred <= dec_pred;
    end else if (IN_ready) begin
      OUT_valid <= 1'b0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{IN_pc[0], IN_BP_branchSrc[0], IN_BP_branchDst[0],
                         s1.start[SLOT_W_MAX-1:SW], s1.end_slot[SLOT_W_MAX-1:SW],
                         s1.bslot[SLOT_W_MAX-1:SW], s1.bid[BID_W_MAX-1:BID_W]};

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - self-checking bench for fetch_pc_gen
module tb_fetch_pc_gen;

  localparam int          N     = 4;
  localparam int          BW    = 6;
  localparam logic [31:0] RSTPC = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            IN_write;
  logic [31:0]     IN_pc;
  logic            IN_BP_branchFound;
  logic            IN_BP_branchTaken;
  logic            IN_BP_isJump;
  logic [31:0]     IN_BP_branchSrc;
  logic [31:0]     IN_BP_branchDst;
  logic [BW-1:0]   IN_BP_branchID;
  logic            IN_BP_multipleBranches;
  logic [N*32-1:0] IN_instr;
  logic            IN_ready;
  logic [31:0]     IN_instrMappingBase;
  logic [31:0]     IN_instrMappingMask;
  logic [31:0]     OUT_pcRaw;
  logic            OUT_fetchEn;
  logic            OUT_valid;
  logic [N*32-1:0] OUT_pc;
  logic [N*32-1:0] OUT_instr;
  logic [N-1:0]    OUT_instrValid;
  logic [N*BW-1:0] OUT_branchID;
  logic [N-1:0]    OUT_branchPred;
  logic            OUT_instrMappingMiss;

  fetch_pc_gen #(.NUM_UOPS(N), .BID_W(BW), .RESET_PC(RSTPC)) dut (
    .clk(clk), .rst(rst), .IN_write(IN_write), .IN_pc(IN_pc),
    .IN_BP_branchFound(IN_BP_branchFound), .IN_BP_branchTaken(IN_BP_branchTaken),
    .IN_BP_isJump(IN_BP_isJump), .IN_BP_branchSrc(IN_BP_branchSrc),
    .IN_BP_branchDst(IN_BP_branchDst), .IN_BP_branchID(IN_BP_branchID),
    .IN_BP_multipleBranches(IN_BP_multipleBranches), .IN_instr(IN_instr),
    .IN_ready(IN_ready), .IN_instrMappingBase(IN_instrMappingBase),
    .IN_instrMappingMask(IN_instrMappingMask), .OUT_pcRaw(OUT_pcRaw),
    .OUT_fetchEn(OUT_fetchEn), .OUT_valid(OUT_valid), .OUT_pc(OUT_pc),
    .OUT_instr(OUT_instr), .OUT_instrValid(OUT_instrValid),
    .OUT_branchID(OUT_branchID), .OUT_branchPred(OUT_branchPred),
    .OUT_instrMappingMiss(OUT_instrMappingMiss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*32-1:0] pc;
    logic [N*32-1:0] instr;
    logic [N-1:0]    mask;
    logic [N*BW-1:0] id;
    logic [N-1:0]    pred;
  } blk_t;

  int          tests = 0;
  int          fails = 0;
  blk_t        q[$];
  logic [31:0] mpc;
  logic [N*32-1:0] held_pc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: each word is derived from its own byte address.
  function automatic logic [N*32-1:0] mem_blk(input logic [31:0] a);
    logic [31:0] base;
    logic [N*32-1:0] r;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = (base + 32'(4 * i)) ^ 32'hC3A5_0000;
    return r;
  endfunction

  // Reference: what block a fetch at p yields and where the next fetch goes.
  task automatic model_fetch(input logic [31:0] p, output blk_t b, output logic [31:0] nxt);
    logic [31:0] base;
    int s, e, bs;
    base   = p & 32'hFFFF_FFF0;
    s      = int'(p[3:2]);
    e      = N - 1;
    nxt    = base + 32'(N * 4);
    b.pred = '0;
    b.id   = '1;
    if (IN_BP_branchFound) begin
      bs = int'(IN_BP_branchSrc[3:2]);
      b.id[bs*BW +: BW] = IN_BP_branchID;
      if (IN_BP_branchTaken || IN_BP_isJump) begin
        e = bs; b.pred[bs] = 1'b1; nxt = IN_BP_branchDst & ~32'd1;
      end else if (IN_BP_multipleBranches) begin
        e = bs; nxt = (IN_BP_branchSrc + 32'd4) & ~32'd1;
      end
    end
    for (int i = 0; i < N; i++) begin
      b.pc[i*32 +: 32] = base + 32'(4 * i);
      b.mask[i]        = (i >= s) && (i <= e);
    end
    b.instr = mem_blk(p);
  endtask

  task automatic step();
    logic fe, acc;
    logic [31:0] pr, nxt;
    blk_t e, nb;
    #1;
    fe  = OUT_fetchEn;
    pr  = OUT_pcRaw;
    acc = OUT_valid && IN_ready && !IN_write;
    chk("pc_raw", 128'(pr), 128'(mpc));
    if (acc) begin
      if (q.size() == 0) begin
        chk("unexpected_block", 128'(q.size()), 128'(1));
      end else begin
        e = q.pop_front();
        chk("blk_pc", 128'(OUT_pc), 128'(e.pc));
        chk("blk_instr", 128'(OUT_instr), 128'(e.instr));
        chk("blk_mask", 128'(OUT_instrValid), 128'(e.mask));
        chk("blk_id", 128'(OUT_branchID), 128'(e.id));
        chk("blk_pred", 128'(OUT_branchPred), 128'(e.pred));
      end
    end
    if (IN_write) begin
      q.delete();
      mpc = IN_pc & ~32'd1;
    end else if (fe) begin
      model_fetch(pr, nb, nxt);
      q.push_back(nb);
      mpc = nxt;
    end
    @(posedge clk);
    #1;
    if (fe && !IN_write) IN_instr = mem_blk(pr);
  endtask

  task automatic bp_off();
    IN_BP_branchFound = 1'b0; IN_BP_branchTaken = 1'b0; IN_BP_isJump = 1'b0;
    IN_BP_multipleBranches = 1'b0; IN_BP_branchSrc = '0; IN_BP_branchDst = '0;
    IN_BP_branchID = '0;
  endtask

  task automatic bp_rand();
    int slot;
    slot = $urandom_range(N - 1, int'(mpc[3:2]));
    IN_BP_branchFound      = 1'($urandom_range(0, 1));
    IN_BP_branchTaken      = 1'($urandom_range(0, 1));
    IN_BP_isJump           = ($urandom_range(0, 7) == 0);
    IN_BP_multipleBranches = 1'($urandom_range(0, 1));
    IN_BP_branchSrc        = (mpc & 32'hFFFF_FFF0) | 32'(slot * 4);
    IN_BP_branchDst        = $urandom;
    IN_BP_branchID         = BW'($urandom_range(0, 62));
  endtask

  task automatic redirect(input logic [31:0] a);
    IN_write = 1'b1; IN_pc = a;
    step();
    IN_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; IN_write = 1'b0; IN_pc = '0; IN_instr = '0; IN_ready = 1'b1;
    IN_instrMappingBase = '0; IN_instrMappingMask = '0;
    bp_off();
    mpc = RSTPC;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(OUT_valid), 128'(0));
    chk("rst_pcraw", 128'(OUT_pcRaw), 128'(RSTPC));
    chk("rst_pc", 128'(OUT_pc), 128'(0));
    chk("rst_instr", 128'(OUT_instr), 128'(0));
    chk("rst_mask", 128'(OUT_instrValid), 128'(0));
    chk("rst_id", 128'(OUT_branchID), 128'(24'hFFFFFF));
    chk("rst_pred", 128'(OUT_branchPred), 128'(0));
    rst = 1'b1;
    #1;
    chk("rst_fetchen", 128'(OUT_fetchEn), 128'(1));
    step();
    chk("seq_pc1", 128'(OUT_pcRaw), 128'(32'h8000_0010));
    step();
    chk("seq_pc2", 128'(OUT_pcRaw), 128'(32'h8000_0020));
    chk("seq_valid", 128'(OUT_valid), 128'(1));
    chk("seq_blk", 128'(OUT_pc), {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000});
    chk("seq_mask", 128'(OUT_instrValid), 128'(4'b1111));
    chk("seq_id", 128'(OUT_branchID), 128'(24'hFFFFFF));

    // Redirect into the middle of a block.
    redirect(32'h0000_1008);
    chk("redir_valid", 128'(OUT_valid), 128'(0));
    chk("redir_pcraw", 128'(OUT_pcRaw), 128'(32'h1008));
    step();
    chk("redir_next", 128'(OUT_pcRaw), 128'(32'h1010));
    step();
    chk("redir_blk", 128'(OUT_pc), {32'h100C, 32'h1008, 32'h1004, 32'h1000});
    chk("redir_mask", 128'(OUT_instrValid), 128'(4'b1100));

    // Taken branch.
    redirect(32'h0000_2000);
    IN_BP_branchFound = 1'b1; IN_BP_branchTaken = 1'b1;
    IN_BP_branchSrc = 32'h2004; IN_BP_branchDst = 32'h3006; IN_BP_branchID = 6'd5;
    step();
    bp_off();
    chk("tkn_pcraw", 128'(OUT_pcRaw), 128'(32'h3006));
    step();
    chk("tkn_mask", 128'(OUT_instrValid), 128'(4'b0011));
    chk("tkn_id", 128'(OUT_branchID), 128'(24'hFFF17F));
    chk("tkn_pred", 128'(OUT_branchPred), 128'(4'b0010));
    step();
    chk("tgt_mask", 128'(OUT_instrValid), 128'(4'b1110));
    chk("tgt_blk", 128'(OUT_pc), {32'h300C, 32'h3008, 32'h3004, 32'h3000});

    // Not taken with further branches behind it.
    redirect(32'h0000_2000);
    IN_BP_branchFound = 1'b1; IN_BP_multipleBranches = 1'b1;
    IN_BP_branchSrc = 32'h2008; IN_BP_branchDst = 32'h7000; IN_BP_branchID = 6'd9;
    step();
    bp_off();
    chk("nt_pcraw", 128'(OUT_pcRaw), 128'(32'h200C));
    step();
    chk("nt_mask", 128'(OUT_instrValid), 128'(4'b0111));
    chk("nt_pred", 128'(OUT_branchPred), 128'(4'b0000));

    // Back-pressure: hold for three cycles, then the sequence must resume intact.
    step(); step();
    IN_ready = 1'b0;
    held_pc = OUT_pc;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 128'(OUT_valid), 128'(1));
      chk("bp_hold", 128'(OUT_pc), 128'(held_pc));
      chk("bp_fetchen", 128'(OUT_fetchEn), 128'(0));
    end
    IN_ready = 1'b1;
    repeat (4) step();

    // Redirect while stalled, then the mapping window compare.
    IN_ready = 1'b0;
    step(); step();
    redirect(32'h1000_4000);
    chk("stall_redir_valid", 128'(OUT_valid), 128'(0));
    IN_instrMappingBase = 32'h1000_0000; IN_instrMappingMask = 32'hFFFF_C000;
    #1;
    chk("map_miss1", 128'(OUT_instrMappingMiss), 128'(1));
    redirect(32'h1000_3FFC);
    #1;
    chk("map_miss0", 128'(OUT_instrMappingMiss), 128'(0));
    IN_ready = 1'b1;

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      IN_ready = ($urandom_range(0, 3) != 0);
      IN_instrMappingBase = $urandom;
      IN_instrMappingMask = $urandom & 32'hF000_000C;
      if ($urandom_range(0, 31) == 0) begin
        bp_off();
        redirect($urandom);
      end else begin
        bp_rand();
        step();
      end
      chk("rnd_map", 128'(OUT_instrMappingMiss),
          128'(|((mpc ^ IN_instrMappingBase) & IN_instrMappingMask)));
    end

    // Asynchronous reset in the middle of a stall.
    bp_off();
    IN_ready = 1'b1;
    step(); step();
    IN_ready = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 128'(OUT_valid), 128'(0));
    chk("arst_pcraw", 128'(OUT_pcRaw), 128'(RSTPC));
    chk("arst_id", 128'(OUT_branchID), 128'(24'hFFFFFF));
    chk("arst_mask", 128'(OUT_instrValid), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    mpc = RSTPC;
    IN_ready = 1'b1;
    chk("arst_fetchen", 128'(OUT_fetchEn), 128'(1));
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
